// File: rtl/axi_aw_rand_driver.sv
// -----------------------------------------------------------------------------
// axi_aw_rand_driver
// Random AXI write-address generator for the crossbar testbench. Builds one AW
// request per LFSR word, advances the LFSR on every accepted AW, tracks
// outstanding writes through the B channel, throttles at MAX_OSTD and raises
// a sticky done once NB_REQ requests have been issued and all B responses
// have come back.
//
// Ports:
//   aclk, aresetn   clock, async active-low reset
//   srst            sync active-high reset (same effect as aresetn)
//   en              run enable, sampled in IDLE and LOAD
//   lfsr            random word from the upstream LFSR
//   lfsr_en         advance strobe to the LFSR (= AW handshake)
//   aw*             AXI write-address channel
//   bvalid/bready   AXI write-response handshake
//   ostd            writes accepted on AW but not yet answered on B
//   req_cnt         AW handshakes since reset
//   done            all requests issued and drained (sticky)
//   err             B response seen with nothing outstanding (sticky)
// -----------------------------------------------------------------------------
module axi_aw_rand_driver #(
  parameter int                  AXI_ADDR_W = 16,
  parameter int                  AXI_ID_W   = 8,
  parameter logic [AXI_ID_W-1:0] MST_ID     = 'h10,
  parameter int                  MAX_OSTD   = 4,
  parameter int                  NB_REQ     = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  input  logic                  en,
  input  logic [31:0]           lfsr,
  output logic                  lfsr_en,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [AXI_ADDR_W-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic [AXI_ID_W-1:0]   awid,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [7:0]            ostd,
  output logic [15:0]           req_cnt,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_THROTTLE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state;
  logic        aw_hs, b_hs, b_bad, b_ok;
  logic [7:0]  ostd_nxt;
  logic [15:0] req_nxt;
  logic        lfsr_unused;

  assign aw_hs   = awvalid & awready;
  assign b_hs    = bvalid & bready;
  // A B beat with nothing outstanding is flagged and otherwise dropped, so
  // the counter can never underflow.
  assign b_bad   = b_hs & (ostd == 8'd0);
  assign b_ok    = b_hs & ~b_bad;
  assign ostd_nxt = ostd + 8'(aw_hs) - 8'(b_ok);
  assign req_nxt  = req_cnt + 16'd1;

  // LFSR advances on the same edge the current word is consumed.
  assign lfsr_en = aw_hs;
  assign awid    = MST_ID;

  // Only part of the LFSR word feeds the request.
  assign lfsr_unused = ^lfsr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      awvalid <= 1'b0;
      awaddr  <= '0;
      awlen   <= '0;
      bready  <= 1'b0;
      ostd    <= '0;
      req_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else if (srst) begin
      state   <= S_IDLE;
      awvalid <= 1'b0;
      awaddr  <= '0;
      awlen   <= '0;
      bready  <= 1'b0;
      ostd    <= '0;
      req_cnt <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      bready <= 1'b1;
      ostd   <= ostd_nxt;
      if (b_bad) err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (en) state <= S_LOAD;
        end

        S_LOAD: begin
          if (!en) begin
            state <= S_IDLE;
          end else begin
            awaddr  <= {lfsr[AXI_ADDR_W-1:2], 2'b00};
            awlen   <= {4'h0, lfsr[31:28]};
            awvalid <= 1'b1;
            state   <= S_ISSUE;
          end
        end

        // Valid is held until accepted; en is deliberately ignored here.
        S_ISSUE: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            req_cnt <= req_nxt;
            if (req_nxt == 16'(NB_REQ))
              state <= S_DRAIN;
            else if (ostd_nxt == 8'(MAX_OSTD))
              state <= S_THROTTLE;
            else
              state <= S_LOAD;
          end
        end

        S_THROTTLE: begin
          if (ostd < 8'(MAX_OSTD)) state <= S_LOAD;
        end

        S_DRAIN: begin
          if (ostd == 8'd0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_DONE: begin
          done    <= 1'b1;
          awvalid <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_aw_rand_driver.sv
module tb_axi_aw_rand_driver;
  localparam int AW = 16;
  localparam int IW = 8;
  localparam int MO = 2;
  localparam int NR = 4;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          srst = 1'b0;
  logic          en = 1'b0;
  logic [31:0]   lfsr = '0;
  logic          lfsr_en;
  logic          awvalid;
  logic          awready = 1'b0;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [IW-1:0] awid;
  logic          bvalid = 1'b0;
  logic          bready;
  logic [7:0]    ostd;
  logic [15:0]   req_cnt;
  logic          done;
  logic          err;

  axi_aw_rand_driver #(
    .AXI_ADDR_W(AW), .AXI_ID_W(IW), .MST_ID(8'h10), .MAX_OSTD(MO), .NB_REQ(NR)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .en(en), .lfsr(lfsr),
    .lfsr_en(lfsr_en), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awlen(awlen), .awid(awid), .bvalid(bvalid), .bready(bready), .ostd(ostd),
    .req_cnt(req_cnt), .done(done), .err(err)
  );

  always #5 aclk = ~aclk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Transaction-level reference: counts of accepted AW / B beats, and the
  // LFSR word each request must be derived from.
  int          m_ostd, m_req;
  bit          m_err, m_brdy, m_fin, m_done;
  bit          prev_stall, prev_hs;
  logic [AW-1:0] prev_addr;
  logic [7:0]  prev_len;
  logic [31:0] lq[$];
  logic [15:0] ea[$];
  logic [7:0]  el[$];

  task automatic model_reset();
    m_ostd = 0; m_req = 0; m_err = 0; m_brdy = 0; m_fin = 0; m_done = 0;
    prev_stall = 0; prev_hs = 0;
  endtask

  function automatic logic [31:0] next_word();
    if (lq.size() > 0) return lq.pop_front();
    return $urandom;
  endfunction

  task automatic rst_chk(input string p);
    chk({p, "_awvalid"}, awvalid, 0);
    chk({p, "_awaddr"},  awaddr, 0);
    chk({p, "_awlen"},   awlen, 0);
    chk({p, "_awid"},    awid, 'h10);
    chk({p, "_bready"},  bready, 0);
    chk({p, "_ostd"},    ostd, 0);
    chk({p, "_req_cnt"}, req_cnt, 0);
    chk({p, "_done"},    done, 0);
    chk({p, "_err"},     err, 0);
  endtask

  // One clock: inputs already set at the falling edge.
  task automatic step();
    bit aw_hs, b_hs;
    #1;
    chk("lfsr_en", lfsr_en, awvalid & awready);
    chk("awid", awid, 'h10);
    if (prev_stall) begin
      chk("hold_vld", awvalid, 1);
      chk("hold_addr", awaddr, prev_addr);
      chk("hold_len", awlen, prev_len);
    end
    if (prev_hs) chk("aw_gap", awvalid, 0);
    if (awvalid) chk("ostd_room", m_ostd < MO, 1);
    if (m_req == NR) chk("no_extra_aw", awvalid, 0);
    aw_hs = awvalid && awready;
    b_hs  = bvalid && bready;
    if (aw_hs) begin
      chk("awaddr", awaddr, (lfsr % (1 << AW)) / 4 * 4);
      chk("awlen", awlen, lfsr / (1 << 28));
      if (ea.size() > 0) begin
        chk("awaddr_const", awaddr, ea.pop_front());
        chk("awlen_const", awlen, el.pop_front());
      end
      m_req++;
    end
    prev_stall = awvalid && !awready;
    prev_hs    = aw_hs;
    prev_addr  = awaddr;
    prev_len   = awlen;
    if (b_hs) begin
      if (m_ostd == 0) m_err = 1;
      else m_ostd--;
    end
    if (aw_hs) m_ostd++;
    @(posedge aclk);
    #1;
    if (aw_hs) lfsr = next_word();
    if (srst) model_reset();
    else begin
      m_brdy = 1;
      m_done = m_done | m_fin;
      m_fin  = (m_req == NR) && (m_ostd == 0);
    end
    @(negedge aclk);
    chk("ostd", ostd, m_ostd);
    chk("req_cnt", req_cnt, m_req);
    chk("err", err, m_err);
    chk("done", done, m_done);
    chk("bready", bready, m_brdy);
  endtask

  task automatic areset();
    aresetn = 0; srst = 0; bvalid = 0; awready = 0; en = 0;
    #3;
    model_reset();
    @(negedge aclk);
    aresetn = 1;
  endtask

  initial begin
    model_reset();
    #12;
    rst_chk("rst");

    // Basic issue, throttle, backpressure, simultaneous handshakes, drain.
    lq.push_back(32'h3000_1235);
    lq.push_back(32'h5000_ABCF);
    ea.push_back(16'h1234); el.push_back(8'd3);
    ea.push_back(16'hABCC); el.push_back(8'd5);
    lfsr = next_word();
    @(negedge aclk);
    aresetn = 1;
    en = 1; awready = 1;
    step(); chk("lat_load", awvalid, 0);
    step(); chk("lat_issue", awvalid, 1);
    repeat (12) step();
    chk("thr_ostd", ostd, 2);
    chk("thr_vld", awvalid, 0);
    chk("thr_req", req_cnt, 2);
    awready = 0; bvalid = 1;
    step();
    bvalid = 0;
    chk("one_b_ostd", ostd, 1);
    for (int i = 0; i < 10 && !awvalid; i++) step();
    chk("third_vld", awvalid, 1);
    repeat (5) step();
    chk("bp_req", req_cnt, 2);
    awready = 1; bvalid = 1;
    step();
    bvalid = 0;
    chk("sim_ostd", ostd, 1);
    chk("bp_req_inc", req_cnt, 3);
    for (int i = 0; i < 60 && !done; i++) begin
      bvalid = (m_ostd > 0) && ($urandom_range(0, 2) == 0);
      step();
    end
    bvalid = 0;
    chk("basic_done", done, 1);
    chk("basic_err", err, 0);

    // Spurious B straight after reset release.
    areset();
    bvalid = 1;
    step(); step();
    bvalid = 0;
    step();
    chk("spur_err", err, 1);
    chk("spur_ostd", ostd, 0);
    repeat (2) step();
    chk("spur_sticky", err, 1);

    // Async reset while an AW is pending.
    areset();
    en = 1; awready = 1;
    for (int i = 0; i < 10 && m_req == 0; i++) step();
    awready = 0;
    for (int i = 0; i < 10 && !awvalid; i++) step();
    chk("ar_pre_vld", awvalid, 1);
    chk("ar_pre_req", req_cnt, 1);
    #2;
    aresetn = 0;
    #1;
    chk("ar_vld", awvalid, 0);
    chk("ar_req", req_cnt, 0);
    chk("ar_ostd", ostd, 0);
    en = 0;
    model_reset();
    @(negedge aclk);
    aresetn = 1;

    // Sync reset while throttled.
    areset();
    en = 1; awready = 1;
    for (int i = 0; i < 20 && !(m_ostd == MO && !awvalid && !prev_hs); i++) step();
    chk("sr_pre_ostd", ostd, MO);
    srst = 1;
    step();
    srst = 0; en = 0;
    chk("sr_ostd", ostd, 0);
    chk("sr_vld", awvalid, 0);
    chk("sr_req", req_cnt, 0);
    step();
    chk("sr_idle", awvalid, 0);

    // Randomized runs against the reference.
    for (int r = 0; r < 6; r++) begin
      areset();
      for (int i = 0; i < 400 && !done; i++) begin
        en      = ($urandom_range(0, 7) != 0);
        awready = $urandom_range(0, 1);
        bvalid  = (m_ostd > 0) && ($urandom_range(0, 2) == 0);
        step();
      end
      bvalid = 0;
      chk("rnd_done", done, 1);
      chk("rnd_req", req_cnt, NR);
      chk("rnd_err", err, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
